// File: rtl/keccak_pi_inv_stream.sv
// keccak_pi_inv_stream
//   Lane-serial inverse of the Keccak pi step. A full 25-lane state arrives
//   one lane per accepted beat in natural order (index 5*i+j). It is buffered,
//   then replayed one lane per beat in inverse-pi order. Fill and drain
//   alternate on a single buffer, so they never overlap.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (clears buffer, returns to FILL)
//   clear      synchronous abort, wins over both handshakes
//   in_valid   in_lane holds a lane
//   in_ready   block accepts a lane this cycle (high only while filling)
//   in_lane    input lane, index implied by arrival order
//   out_valid  out_lane holds a lane (high only while draining)
//   out_ready  downstream accepts out_lane this cycle
//   out_lane   output lane, inverse-pi order
//   out_last   marks the 25th output lane
//
// state | meaning
// FILL  | accepting lanes 0..24 into buffer[cnt]
// DRAIN | presenting buffer[src(cnt)] for cnt = 0..24
module keccak_pi_inv_stream #(
  parameter int l = 6,
  parameter int w = 2**l
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [w-1:0] in_lane,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w-1:0] out_lane,
  output logic         out_last
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [4:0]   src_idx;
  logic         wr_en;
  logic [w-1:0] lanes_q [25];

  // Output lane k = 5p+q reads buffered lane 5q + ((2p+q) mod 5).
  // Kept as a constant table so no modulo hardware is built.
  always_comb begin
    src_idx = 5'd0;
    case (cnt_q)
      5'd0:  src_idx = 5'd0;
      5'd1:  src_idx = 5'd6;
      5'd2:  src_idx = 5'd12;
      5'd3:  src_idx = 5'd18;
      5'd4:  src_idx = 5'd24;
      5'd5:  src_idx = 5'd2;
      5'd6:  src_idx = 5'd8;
      5'd7:  src_idx = 5'd14;
      5'd8:  src_idx = 5'd15;
      5'd9:  src_idx = 5'd21;
      5'd10: src_idx = 5'd4;
      5'd11: src_idx = 5'd5;
      5'd12: src_idx = 5'd11;
      5'd13: src_idx = 5'd17;
      5'd14: src_idx = 5'd23;
      5'd15: src_idx = 5'd1;
      5'd16: src_idx = 5'd7;
      5'd17: src_idx = 5'd13;
      5'd18: src_idx = 5'd19;
      5'd19: src_idx = 5'd20;
      5'd20: src_idx = 5'd3;
      5'd21: src_idx = 5'd9;
      5'd22: src_idx = 5'd10;
      5'd23: src_idx = 5'd16;
      5'd24: src_idx = 5'd22;
      default: src_idx = 5'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == 5'd24) begin
            state_d = DRAIN;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == 5'd24);
        if (out_ready) begin
          if (cnt_q == 5'd24) begin
            state_d = FILL;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = 5'd0;
      end
    endcase
    // abort overrides any handshake, including a write in the same cycle
    if (clear) begin
      state_d = FILL;
      cnt_d   = 5'd0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) lanes_q[i] <= '0;
    end else if (wr_en) begin
      lanes_q[cnt_q] <= in_lane;
    end
  end

  // Buffer is always initialised, so this never carries X even outside DRAIN.
  assign out_lane = lanes_q[src_idx];

endmodule

// File: tb/tb_keccak_pi_inv_stream.sv
module tb_keccak_pi_inv_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [63:0] in_lane, out_lane;
  logic        clear8, in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
  logic [7:0]  in_lane8, out_lane8;

  keccak_pi_inv_stream dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane(in_lane),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_last(out_last)
  );

  keccak_pi_inv_stream #(.l(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_lane(in_lane8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_lane(out_lane8),
    .out_last(out_last8)
  );

  typedef struct {
    logic [63:0] lane;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   drain_idx = 0;
  int   rdy_mode = 2;   // 0: ready always, 1: ready 30% random, 2: driven by main
  int   src_tab[25] = '{0, 6, 12, 18, 24, 2, 8, 14, 15, 21, 4, 5, 11, 17, 23,
                        1, 7, 13, 19, 20, 3, 9, 10, 16, 22};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver, changes just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 9) < 3);
  end

  // monitor: pop and compare on every output transfer, check stall stability
  logic [63:0] held_lane;
  logic        held_last;
  bit          stalled = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      chk1("in_ready_in_drain", in_ready, 1'b0);
      if (stalled) begin
        chk("stall_lane", out_lane, held_lane);
        chk1("stall_last", out_last, held_last);
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %0h expected no output", out_lane);
        end else begin
          e = q.pop_front();
          chk("out_lane", out_lane, e.lane);
          chk1("out_last", out_last, e.last);
        end
        stalled = 0;
        drain_idx = out_last ? 0 : drain_idx + 1;
      end else begin
        stalled   = 1;
        held_lane = out_lane;
        held_last = out_last;
      end
    end else begin
      stalled = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out8: got %0h expected no output", out_lane8);
      end else begin
        e = q8.pop_front();
        chk("out_lane8", 64'(out_lane8), e.lane);
        chk1("out_last8", out_last8, e.last);
      end
    end
  end

  task automatic send(input logic [63:0] v, input int gapmax);
    int  t;
    logic acc;
    repeat ($urandom_range(0, gapmax)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_lane  = v;
    t = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 300 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_identity();
    for (int k = 0; k < 25; k++) q.push_back('{64'(src_tab[k]), k == 24});
  endtask

  task automatic wait_drained();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d lanes pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] x [25];
    logic [63:0] y [25];
    int t;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_lane = '0; out_ready = 1'b0;
    clear8 = 1'b0; in_valid8 = 1'b0; in_lane8 = '0; out_ready8 = 1'b1;
    #12;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk("rst_out_lane", out_lane, 64'd0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // identity order
    rdy_mode = 0;
    push_identity();
    for (int k = 0; k < 25; k++) send(64'(k), 0);
    chk1("first_valid_latency", out_valid, 1'b1);
    wait_drained();

    // round trip through forward pi
    for (int s = 0; s < 100; s++) begin
      for (int k = 0; k < 25; k++) begin
        x[k] = {$urandom, $urandom};
        q.push_back('{x[k], k == 24});
      end
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          y[5*i+j] = x[5*((2*i+3*j)%5)+i];
      for (int k = 0; k < 25; k++) send(y[k], 0);
    end
    wait_drained();

    // backpressure on both sides
    rdy_mode = 1;
    push_identity();
    for (int k = 0; k < 25; k++) send(64'(k), 3);
    wait_drained();
    rdy_mode = 0;

    // clear after 10 accepts, with a lane offered on the clear cycle
    for (int k = 0; k < 10; k++) send(64'(50 + k), 0);
    clear = 1'b1; in_valid = 1'b1; in_lane = 64'd999;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk1("clear_fill_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 25; k++) q.push_back('{64'(100 + src_tab[k]), k == 24});
    for (int k = 0; k < 25; k++) send(64'(100 + k), 0);
    wait_drained();

    // clear at drain cnt = 7
    rdy_mode = 2; out_ready = 1'b1;
    drain_idx = 0;
    push_identity();
    for (int k = 0; k < 25; k++) send(64'(k), 0);
    t = 0;
    while (drain_idx < 7 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_idx_at_clear", 64'(drain_idx), 64'd7);
    clear = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    chk1("clear_drain_in_ready", in_ready, 1'b1);
    chk1("clear_drain_out_valid", out_valid, 1'b0);
    q.delete();
    drain_idx = 0;
    rdy_mode = 0;
    @(posedge clk); #1;

    // async reset mid-drain
    push_identity();
    for (int k = 0; k < 25; k++) send(64'(k + 1000), 0);
    q.delete();
    for (int k = 0; k < 25; k++) q.push_back('{64'(1000 + src_tab[k]), k == 24});
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chk1("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_lane", out_lane, 64'd0);
    q.delete();
    drain_idx = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_lane", out_lane, 64'd0);
    push_identity();
    for (int k = 0; k < 25; k++) send(64'(k), 0);
    wait_drained();

    // 8-bit lane instance
    for (int k = 0; k < 25; k++) q8.push_back('{64'(src_tab[k]), k == 24});
    for (int k = 0; k < 25; k++) begin
      in_valid8 = 1'b1;
      in_lane8  = 8'(k);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    t = 0;
    while (q8.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (q8.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain8_timeout: got %0d lanes pending expected 0", q8.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
